// File: rtl/tx_link_sequencer_if.sv
// rtl/tx_link_sequencer_if.sv - MAC-side and PCS-side signal bundle of the transmit link sequencer
interface tx_link_sequencer_if;
   logic        link_en;
   logic [31:0] mac_tx_data;
   logic [3:0]  mac_tx_datak;
   logic        mac_data_en;
   logic        mac_tx_ready;
   logic [31:0] pcs_tx_data;
   logic [3:0]  pcs_tx_datak;
   logic        pcs_data_en;
   logic        link_up;

   modport master (
      output link_en, mac_tx_data, mac_tx_datak, mac_data_en,
      input  mac_tx_ready, pcs_tx_data, pcs_tx_datak, pcs_data_en, link_up
   );

   modport slave (
      input  link_en, mac_tx_data, mac_tx_datak, mac_data_en,
      output mac_tx_ready, pcs_tx_data, pcs_tx_datak, pcs_data_en, link_up
   );
endinterface

// File: rtl/tx_link_sequencer.sv
// rtl/tx_link_sequencer.sv - TS1 training burst, then MAC pass-through with SKP insertion and logical idle
module tx_link_sequencer #(
   parameter int          SKP_INTERVAL = 1180,
   parameter int          TS_COUNT     = 16,
   parameter logic [7:0]  N_FTS        = 8'h80
) (
   input logic                pclk,
   input logic                rst,
   tx_link_sequencer_if.slave bus
);

   localparam int SKP_W = $clog2(SKP_INTERVAL);
   localparam int SET_W = (TS_COUNT > 1) ? $clog2(TS_COUNT) : 1;

   localparam logic [31:0] SKP_DATA = 32'h1C1C1CBC;

   typedef enum logic [1:0] {IDLE, TRAIN, DATA} state_t;

   state_t             state, state_n;
   logic [1:0]         word_cnt, word_cnt_n;
   logic [SET_W-1:0]   set_cnt, set_cnt_n;
   logic [SKP_W-1:0]   skp_cnt, skp_cnt_n;
   logic               skp_pending, skp_pending_n;
   logic [31:0]        pcs_data, pcs_data_n;
   logic [3:0]         pcs_k, pcs_k_n;
   logic               pcs_en, pcs_en_n;

   // Returns {K, data} for the given word of a TS1 ordered set.
   function automatic logic [35:0] ts1_word(input logic [1:0] idx);
      case (idx)
         2'd0:    ts1_word = {4'b0111, N_FTS, 24'hF7F7BC};
         2'd1:    ts1_word = {4'b0000, 32'h4A4A0002};
         default: ts1_word = {4'b0000, 32'h4A4A4A4A};
      endcase
   endfunction

   always_comb begin
      state_n       = state;
      word_cnt_n    = word_cnt;
      set_cnt_n     = set_cnt;
      skp_cnt_n     = skp_cnt;
      skp_pending_n = skp_pending;
      pcs_data_n    = '0;
      pcs_k_n       = '0;
      pcs_en_n      = 1'b0;

      if (!bus.link_en) begin
         state_n       = IDLE;
         word_cnt_n    = '0;
         set_cnt_n     = '0;
         skp_cnt_n     = '0;
         skp_pending_n = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state_n              = TRAIN;
               word_cnt_n           = '0;
               set_cnt_n            = '0;
               {pcs_k_n, pcs_data_n} = ts1_word(2'd0);
               pcs_en_n             = 1'b1;
            end
            TRAIN: begin
               pcs_en_n = 1'b1;
               if (word_cnt == 2'd3 && set_cnt == SET_W'(TS_COUNT - 1)) begin
                  state_n       = DATA;
                  skp_cnt_n     = '0;
                  skp_pending_n = 1'b0;
               end else begin
                  word_cnt_n            = word_cnt + 2'd1;
                  {pcs_k_n, pcs_data_n} = ts1_word(word_cnt + 2'd1);
                  if (word_cnt == 2'd3)
                     set_cnt_n = set_cnt + 1'b1;
               end
            end
            DATA: begin
               pcs_en_n = 1'b1;
               if (skp_pending) begin
                  pcs_data_n    = SKP_DATA;
                  pcs_k_n       = 4'hF;
                  skp_pending_n = 1'b0;
               end else if (bus.mac_data_en) begin
                  pcs_data_n = bus.mac_tx_data;
                  pcs_k_n    = bus.mac_tx_datak;
               end
               // Evaluated after the SKP clear so a coincident wrap re-arms the request.
               if (skp_cnt == SKP_W'(SKP_INTERVAL - 1)) begin
                  skp_cnt_n     = '0;
                  skp_pending_n = 1'b1;
               end else begin
                  skp_cnt_n = skp_cnt + 1'b1;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         word_cnt    <= '0;
         set_cnt     <= '0;
         skp_cnt     <= '0;
         skp_pending <= 1'b0;
         pcs_data    <= '0;
         pcs_k       <= '0;
         pcs_en      <= 1'b0;
      end else begin
         state       <= state_n;
         word_cnt    <= word_cnt_n;
         set_cnt     <= set_cnt_n;
         skp_cnt     <= skp_cnt_n;
         skp_pending <= skp_pending_n;
         pcs_data    <= pcs_data_n;
         pcs_k       <= pcs_k_n;
         pcs_en      <= pcs_en_n;
      end
   end

   assign bus.mac_tx_ready = (state == DATA) && !skp_pending;
   assign bus.link_up      = (state == DATA);
   assign bus.pcs_tx_data  = pcs_data;
   assign bus.pcs_tx_datak = pcs_k;
   assign bus.pcs_data_en  = pcs_en;

endmodule

// File: tb/tb_tx_link_sequencer.sv
// tb/tb_tx_link_sequencer.sv - self-checking bench for tx_link_sequencer with a cycle-index reference model
module tb_tx_link_sequencer;

   localparam int SI = 8;
   localparam int TS = 2;
   localparam int NT = 4 * TS;

   logic pclk = 1'b0;
   logic rst  = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   int   seq      = 1;
   logic [31:0] last_mac = 32'h0;
   bit   acc;

   tx_link_sequencer_if bus ();

   tx_link_sequencer #(.SKP_INTERVAL(SI), .TS_COUNT(TS), .N_FTS(8'h80)) dut (
      .pclk (pclk),
      .rst  (rst),
      .bus  (bus)
   );

   always #5 pclk = ~pclk;

   // Model: t = edges since link enable (-1 when down); DATA begins at t = NT.
   function automatic int next_t(input int t, input logic en);
      if (!en) return -1;
      return (t < 0) ? 0 : t + 1;
   endfunction

   function automatic bit skp_at(input int t);
      int d;
      d = t - NT;
      return (d >= 2) && ((d - 1) % SI == 0);
   endfunction

   function automatic bit rdy_of(input int t);
      return (t >= NT) && !skp_at(t + 1);
   endfunction

   function automatic logic [35:0] exp_word(input int nt, input int pt, input logic men,
                                            input logic [3:0] mk, input logic [31:0] md);
      if (nt < 0) return 36'h0;
      if (nt < NT) begin
         case (nt % 4)
            0:       return {4'h7, 32'h80F7F7BC};
            1:       return {4'h0, 32'h4A4A0002};
            default: return {4'h0, 32'h4A4A4A4A};
         endcase
      end
      if (skp_at(nt)) return {4'hF, 32'h1C1C1CBC};
      if (rdy_of(pt) && men) return {mk, md};
      return 36'h0;
   endfunction

   int          m_t = -1;
   logic [31:0] e_data = '0;
   logic [3:0]  e_k = '0;
   logic        e_en = 1'b0, e_up = 1'b0, e_rdy = 1'b0;

   always @(posedge pclk or posedge rst) begin
      if (rst) begin
         m_t    <= -1;
         e_data <= '0;
         e_k    <= '0;
         e_en   <= 1'b0;
         e_up   <= 1'b0;
         e_rdy  <= 1'b0;
      end else begin
         m_t           <= next_t(m_t, bus.link_en);
         {e_k, e_data} <= exp_word(next_t(m_t, bus.link_en), m_t, bus.mac_data_en,
                                   bus.mac_tx_datak, bus.mac_tx_data);
         e_en          <= next_t(m_t, bus.link_en) >= 0;
         e_up          <= next_t(m_t, bus.link_en) >= NT;
         e_rdy         <= rdy_of(next_t(m_t, bus.link_en));
      end
   end

   task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   always @(negedge pclk) begin
      chk("cyc_word", {bus.pcs_tx_datak, bus.pcs_tx_data}, {e_k, e_data});
      chk("cyc_flags", {33'h0, bus.mac_tx_ready, bus.pcs_data_en, bus.link_up},
          {33'h0, e_rdy, e_en, e_up});
      if (bus.link_up && bus.pcs_data_en && bus.pcs_tx_datak != 4'hF && bus.pcs_tx_data != 32'h0) begin
         chk("mac_order", {4'h0, bus.pcs_tx_data}, {4'h0, last_mac + 32'd1});
         last_mac = bus.pcs_tx_data;
      end
   end

   task automatic step();
      @(negedge pclk);
      acc = bus.mac_data_en && bus.mac_tx_ready && bus.link_en && !rst;
      @(posedge pclk);
      #2;
      if (acc) seq++;
      bus.mac_tx_data  = 32'(seq);
      bus.mac_tx_datak = {1'b0, 3'(seq)};
   endtask

   task automatic chk_flags(input string name, input logic [2:0] exp);
      chk(name, {33'h0, bus.mac_tx_ready, bus.pcs_data_en, bus.link_up}, {33'h0, exp});
   endtask

   task automatic chk_out(input string name, input logic [35:0] exp);
      chk(name, {bus.pcs_tx_datak, bus.pcs_tx_data}, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      bus.link_en      = 1'b0;
      bus.mac_data_en  = 1'b0;
      bus.mac_tx_data  = '0;
      bus.mac_tx_datak = '0;

      // T1: reset with random inputs, then idle with link disabled
      repeat (5) begin
         @(posedge pclk);
         #2;
         bus.link_en      = 1'($urandom);
         bus.mac_data_en  = 1'($urandom);
         bus.mac_tx_data  = $urandom;
         bus.mac_tx_datak = 4'($urandom);
      end
      chk_out("rst_word", 36'h0);
      chk_flags("rst_flags", 3'b000);
      bus.link_en      = 1'b0;
      bus.mac_data_en  = 1'b0;
      bus.mac_tx_data  = 32'(seq);
      bus.mac_tx_datak = {1'b0, 3'(seq)};
      rst = 1'b0;
      repeat (10) step();
      chk_out("idle_word", 36'h0);
      chk_flags("idle_flags", 3'b000);

      // T2: two TS1 sets, then DATA
      bus.link_en = 1'b1;
      step(); chk_out("ts_w0", {4'h7, 32'h80F7F7BC}); chk_flags("ts_flags", 3'b010);
      step(); chk_out("ts_w1", {4'h0, 32'h4A4A0002});
      step(); step(); chk_out("ts_w3", {4'h0, 32'h4A4A4A4A});
      step(); chk_out("ts2_w0", {4'h7, 32'h80F7F7BC});
      repeat (3) step(); chk_flags("ts2_end_flags", 3'b010);
      step(); chk_out("data_entry_word", 36'h0); chk_flags("data_entry_flags", 3'b111);

      // T4: logical idle with SKP on schedule
      repeat (8) step();
      chk_out("lidle_word", 36'h0); chk_flags("skp_pending_flags", 3'b011);
      step(); chk_out("skp_word", {4'hF, 32'h1C1C1CBC}); chk_flags("after_skp_flags", 3'b111);
      repeat (12) step();

      // T3: streaming MAC words; 5 SKP slots fall within the next 40 edges
      bus.mac_data_en = 1'b1;
      repeat (40) step();
      chk("accepted_count", 36'(seq), 36'd36);

      // T5: abandon TRAIN at W2, then restart from W0
      bus.link_en = 1'b0;
      step(); chk_out("drop_word", 36'h0); chk_flags("drop_flags", 3'b000);
      bus.link_en = 1'b1;
      step(); step(); step(); chk_out("t5_w2", {4'h0, 32'h4A4A4A4A});
      bus.link_en = 1'b0;
      step(); chk_out("t5_drop_word", 36'h0); chk_flags("t5_drop_flags", 3'b000);
      bus.link_en = 1'b1;
      step(); chk_out("t5_restart_w0", {4'h7, 32'h80F7F7BC});

      // T6: asynchronous reset while a SKP is pending
      repeat (8) step();
      chk_flags("t6_data_flags", 3'b111);
      repeat (8) step();
      chk_flags("t6_pending_flags", 3'b011);
      #1;
      rst = 1'b1;
      #1;
      chk_out("t6_rst_word", 36'h0);
      chk_flags("t6_rst_flags", 3'b000);
      @(posedge pclk);
      #2;
      rst = 1'b0;
      step(); chk_out("t6_w0", {4'h7, 32'h80F7F7BC});
      step(); chk_out("t6_w1", {4'h0, 32'h4A4A0002});
      repeat (6) step(); chk_flags("t6_train_flags", 3'b010);
      step(); chk_flags("t6_up_flags", 3'b111);
      @(negedge pclk);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
